// File: rtl/lcd_scan_pkg.sv
// Shared constants and FSM type for the LCD display scanner.
// Used by lcd_display_scanner and its hex encoder.
package lcd_scan_pkg;

    localparam int LINE_CHARS = 14;
    localparam int NAME_CHARS = 5;
    localparam int COL_SEP    = 5;
    localparam int COL_HEX    = 6;
    localparam int COL_LAST   = LINE_CHARS - 1;

    localparam logic [7:0] SPACE = 8'h20;
    localparam logic [7:0] COLON = 8'h3A;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_CAP,
        ST_EMIT
    } scan_state_e;

endpackage

// File: rtl/hex_ascii_encoder.sv
// Combinational nibble to uppercase ASCII hex digit.
module hex_ascii_encoder (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    always_comb begin
        if (nibble < 4'd10) begin
            ascii = 8'h30 + {4'h0, nibble};
        end else begin
            ascii = 8'h37 + {4'h0, nibble};
        end
    end

endmodule

// File: rtl/lcd_display_scanner.sv
// Scans display entries and streams each as a 14-char text line.
// Optional LCD_SCAN_ZERO_SUPPRESS_EN blanks leading zero hex digits.
module lcd_display_scanner
    import lcd_scan_pkg::*;
#(
    parameter int NUM_ENTRIES    = 6,
    parameter int REFRESH_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [5:0]  display_number,
    input  logic        display_valid,
    input  logic [39:0] display_name,
    input  logic [31:0] display_value,
    output logic        char_valid,
    output logic [7:0]  char_data,
    output logic [5:0]  char_row,
    output logic [3:0]  char_col,
    input  logic        char_ready,
    output logic        scan_done
);

    localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [5:0]       LAST_IDX   = 6'(NUM_ENTRIES);

    scan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       idx_q, idx_d;
    logic             line_valid_q, line_valid_d;
    logic [39:0]      line_name_q, line_name_d;
    logic [31:0]      line_value_q, line_value_d;
    logic [5:0]       num_q, num_d;
    logic             cv_q, cv_d;
    logic [7:0]       cd_q, cd_d;
    logic [5:0]       row_q, row_d;
    logic [3:0]       col_q, col_d;
    logic             done_q, done_d;

    logic             src_valid;
    logic [39:0]      src_name;
    logic [31:0]      src_value;
    logic [3:0]       nxt_col;
    logic [7:0]       name_byte;
    logic [3:0]       nibble;
    logic [7:0]       hex_char;
    logic [7:0]       nxt_char;
`ifdef LCD_SCAN_ZERO_SUPPRESS_EN
    logic             lead_zero;
`endif

    hex_ascii_encoder u_hex (
        .nibble (nibble),
        .ascii  (hex_char)
    );

    // In CAP the first character comes straight from the response inputs
    always_comb begin
        if (state_q == ST_CAP) begin
            src_valid = display_valid;
            src_name  = display_name;
            src_value = display_value;
            nxt_col   = 4'd0;
        end else begin
            src_valid = line_valid_q;
            src_name  = line_name_q;
            src_value = line_value_q;
            nxt_col   = col_q + 4'd1;
        end

        case (nxt_col)
            4'd0:    name_byte = src_name[39:32];
            4'd1:    name_byte = src_name[31:24];
            4'd2:    name_byte = src_name[23:16];
            4'd3:    name_byte = src_name[15:8];
            4'd4:    name_byte = src_name[7:0];
            default: name_byte = 8'h00;
        endcase

        case (nxt_col)
            4'd6:    nibble = src_value[31:28];
            4'd7:    nibble = src_value[27:24];
            4'd8:    nibble = src_value[23:20];
            4'd9:    nibble = src_value[19:16];
            4'd10:   nibble = src_value[15:12];
            4'd11:   nibble = src_value[11:8];
            4'd12:   nibble = src_value[7:4];
            4'd13:   nibble = src_value[3:0];
            default: nibble = 4'h0;
        endcase

        if (!src_valid) begin
            nxt_char = SPACE;
        end else if (nxt_col < 4'(COL_SEP)) begin
            nxt_char = (name_byte == 8'h00) ? SPACE : name_byte;
        end else if (nxt_col == 4'(COL_SEP)) begin
            nxt_char = COLON;
        end else begin
            nxt_char = hex_char;
        end

`ifdef LCD_SCAN_ZERO_SUPPRESS_EN
        case (nxt_col)
            4'd6:    lead_zero = (src_value[31:28] == 4'h0);
            4'd7:    lead_zero = (src_value[31:24] == 8'h0);
            4'd8:    lead_zero = (src_value[31:20] == 12'h0);
            4'd9:    lead_zero = (src_value[31:16] == 16'h0);
            4'd10:   lead_zero = (src_value[31:12] == 20'h0);
            4'd11:   lead_zero = (src_value[31:8] == 24'h0);
            4'd12:   lead_zero = (src_value[31:4] == 28'h0);
            default: lead_zero = 1'b0;
        endcase
        if (src_valid && lead_zero) begin
            nxt_char = SPACE;
        end
`endif
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        line_valid_d = line_valid_q;
        line_name_d  = line_name_q;
        line_value_d = line_value_q;
        num_d        = num_q;
        cv_d         = cv_q;
        cd_d         = cd_q;
        row_d        = row_q;
        col_d        = col_q;
        done_d       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_REQ;
                    idx_d   = 6'd1;
                    num_d   = 6'd1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_REQ: begin
                state_d = ST_CAP;
            end
            ST_CAP: begin
                state_d      = ST_EMIT;
                num_d        = 6'd0;
                line_valid_d = display_valid;
                line_name_d  = display_name;
                line_value_d = display_value;
                cv_d         = 1'b1;
                cd_d         = nxt_char;
                row_d        = idx_q;
                col_d        = 4'd0;
            end
            ST_EMIT: begin
                if (cv_q && char_ready) begin
                    if (col_q == 4'(COL_LAST)) begin
                        cv_d = 1'b0;
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                            cnt_d   = CNT_RELOAD;
                        end else begin
                            state_d = ST_REQ;
                            idx_d   = idx_q + 6'd1;
                            num_d   = idx_q + 6'd1;
                        end
                    end else begin
                        col_d = nxt_col;
                        cd_d  = nxt_char;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            line_valid_q <= 1'b0;
            line_name_q  <= '0;
            line_value_q <= '0;
            num_q        <= '0;
            cv_q         <= 1'b0;
            cd_q         <= '0;
            row_q        <= '0;
            col_q        <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            line_valid_q <= line_valid_d;
            line_name_q  <= line_name_d;
            line_value_q <= line_value_d;
            num_q        <= num_d;
            cv_q         <= cv_d;
            cd_q         <= cd_d;
            row_q        <= row_d;
            col_q        <= col_d;
            done_q       <= done_d;
        end
    end

    assign display_number = num_q;
    assign char_valid     = cv_q;
    assign char_data      = cd_q;
    assign char_row       = row_q;
    assign char_col       = col_q;
    assign scan_done      = done_q;

endmodule

// File: tb/tb_lcd_display_scanner.sv
// Directed bench for lcd_display_scanner with a one-cycle responder model.
module tb_lcd_display_scanner;

    localparam int N = 6;
    localparam int R = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  display_number;
    logic        display_valid = 1'b0;
    logic [39:0] display_name = '0;
    logic [31:0] display_value = '0;
    logic        char_valid;
    logic [7:0]  char_data;
    logic [5:0]  char_row;
    logic [3:0]  char_col;
    logic        char_ready = 1'b1;
    logic        scan_done;
    logic        corrupt = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0]   got [1:N][0:13];
    bit           seen [1:N][0:13];
    logic [111:0] exp_line [1:N];

    int req_cyc, done_cyc, done_cnt, dup_cnt, order_err, stab_err;

    always #5 clk = ~clk;

    lcd_display_scanner #(
        .NUM_ENTRIES    (N),
        .REFRESH_CYCLES (R)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .display_number (display_number),
        .display_valid  (display_valid),
        .display_name   (display_name),
        .display_value  (display_value),
        .char_valid     (char_valid),
        .char_data      (char_data),
        .char_row       (char_row),
        .char_col       (char_col),
        .char_ready     (char_ready),
        .scan_done      (scan_done)
    );

    // Responder: registered answer to the requested entry
    always @(posedge clk) begin
        if (corrupt) begin
            display_valid <= 1'b1;
            display_name  <= "#####";
            display_value <= 32'h1111_1111;
        end else begin
            case (display_number)
                6'd1: begin
                    display_valid <= 1'b1;
                    display_name  <= 40'h41_00_00_00_00;
                    display_value <= 32'h0000_00FF;
                end
                6'd2: begin
                    display_valid <= 1'b1;
                    display_name  <= 40'h42_00_43_00_00;
                    display_value <= 32'h1234_5678;
                end
                6'd3: begin
                    display_valid <= 1'b0;
                    display_name  <= "QQQQQ";
                    display_value <= 32'h0000_0001;
                end
                6'd4: begin
                    display_valid <= 1'b1;
                    display_name  <= "HELLO";
                    display_value <= 32'hDEAD_BEEF;
                end
                6'd5: begin
                    display_valid <= 1'b1;
                    display_name  <= 40'h5A_45_52_4F_00;
                    display_value <= 32'h0000_0000;
                end
                6'd6: begin
                    display_valid <= 1'b1;
                    display_name  <= 40'h58_00_00_00_00;
                    display_value <= 32'h000A_0B0C;
                end
                default: begin
                    display_valid <= 1'b0;
                    display_name  <= '0;
                    display_value <= '0;
                end
            endcase
        end
    end

    function automatic logic [111:0] line_of(input int r);
        logic [111:0] v;
        v = '0;
        for (int c = 0; c < 14; c++) v[111-8*c -: 8] = got[r][c];
        return v;
    endfunction

    task automatic collect_scan(input bit stall2, input bit chg4);
        int cyc, phase, last_row;
        bit stalled;
        logic [7:0] pd;
        logic [5:0] pr;
        logic [3:0] pc;
        for (int r = 1; r <= N; r++)
            for (int c = 0; c < 14; c++) begin
                got[r][c] = 8'h00;
                seen[r][c] = 1'b0;
            end
        cyc = 0; phase = 0; last_row = 0; stalled = 1'b0;
        pd = '0; pr = '0; pc = '0;
        req_cyc = (display_number == 6'd1) ? 0 : -1;
        done_cyc = -1; done_cnt = 0; dup_cnt = 0; order_err = 0; stab_err = 0;
        while (done_cnt == 0 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (req_cyc < 0 && display_number == 6'd1) req_cyc = cyc;
            if (scan_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            corrupt = chg4 && char_valid && (char_row == 6'd4);
            if (stalled && (!char_valid || char_data !== pd ||
                            char_row !== pr || char_col !== pc))
                stab_err++;
            if (stall2 && char_valid && char_row == 6'd2) begin
                char_ready = (phase % 4 == 0);
                phase++;
            end else begin
                char_ready = 1'b1;
            end
            stalled = char_valid && !char_ready;
            pd = char_data; pr = char_row; pc = char_col;
            if (char_valid && char_ready) begin
                if (char_row < 6'd1 || char_row > 6'(N) || char_col > 4'd13) begin
                    order_err++;
                end else begin
                    if (int'(char_row) < last_row) order_err++;
                    last_row = int'(char_row);
                    if (seen[char_row][char_col]) dup_cnt++;
                    seen[char_row][char_col] = 1'b1;
                    got[char_row][char_col] = char_data;
                end
            end
        end
        corrupt = 1'b0;
        char_ready = 1'b1;
    endtask

    task automatic wait_gap(output int gap, output int bad);
        gap = 0;
        bad = (display_number != 6'd0) ? 1 : 0;
        while (display_number != 6'd1 && gap < 100) begin
            @(negedge clk);
            gap++;
            if (display_number > 6'd1) bad++;
            if (scan_done) bad++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        char_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (display_number !== 6'd0) begin
            n_fail++; $display("FAIL reset_display_number got=%0h exp=0", display_number);
        end
        n_checks++;
        if (char_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_char_valid got=%b exp=0", char_valid);
        end
        n_checks++;
        if (char_data !== 8'h00) begin
            n_fail++; $display("FAIL reset_char_data got=%0h exp=0", char_data);
        end
        n_checks++;
        if (char_row !== 6'd0) begin
            n_fail++; $display("FAIL reset_char_row got=%0h exp=0", char_row);
        end
        n_checks++;
        if (char_col !== 4'd0) begin
            n_fail++; $display("FAIL reset_char_col got=%0h exp=0", char_col);
        end
        n_checks++;
        if (scan_done !== 1'b0) begin
            n_fail++; $display("FAIL reset_scan_done got=%b exp=0", scan_done);
        end
        reset = 1'b0;
    endtask

    task automatic test_scan();
        int gap, bad;
        collect_scan(1'b0, 1'b0);
        n_checks++;
        if (req_cyc !== 1) begin
            n_fail++; $display("FAIL first_req_cycle got=%0d exp=1", req_cyc);
        end
        n_checks++;
        if (done_cnt !== 1) begin
            n_fail++; $display("FAIL scan_done_count got=%0d exp=1", done_cnt);
        end
        n_checks++;
        if (done_cyc - req_cyc !== 96) begin
            n_fail++; $display("FAIL scan_length got=%0d exp=96", done_cyc - req_cyc);
        end
        for (int r = 1; r <= N; r++) begin
            n_checks++;
            if (line_of(r) !== exp_line[r]) begin
                n_fail++;
                $display("FAIL scan_row%0d got=\"%s\" exp=\"%s\"", r, line_of(r), exp_line[r]);
            end
        end
        n_checks++;
        if (dup_cnt !== 0 || order_err !== 0) begin
            n_fail++; $display("FAIL scan_order dup=%0d order=%0d exp=0/0", dup_cnt, order_err);
        end
        wait_gap(gap, bad);
        n_checks++;
        if (gap !== R) begin
            n_fail++; $display("FAIL refresh_gap got=%0d exp=%0d", gap, R);
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL refresh_gap_quiet got=%0d exp=0", bad);
        end
    endtask

    task automatic test_stall();
        int gap, bad;
        collect_scan(1'b1, 1'b0);
        n_checks++;
        if (stab_err !== 0) begin
            n_fail++; $display("FAIL stall_stability got=%0d exp=0", stab_err);
        end
        n_checks++;
        if (dup_cnt !== 0 || order_err !== 0) begin
            n_fail++; $display("FAIL stall_order dup=%0d order=%0d exp=0/0", dup_cnt, order_err);
        end
        n_checks++;
        if (done_cyc - req_cyc !== 135) begin
            n_fail++; $display("FAIL stall_scan_length got=%0d exp=135", done_cyc - req_cyc);
        end
        for (int r = 1; r <= N; r++) begin
            n_checks++;
            if (line_of(r) !== exp_line[r]) begin
                n_fail++;
                $display("FAIL stall_row%0d got=\"%s\" exp=\"%s\"", r, line_of(r), exp_line[r]);
            end
        end
        wait_gap(gap, bad);
        n_checks++;
        if (gap !== R) begin
            n_fail++; $display("FAIL stall_refresh_gap got=%0d exp=%0d", gap, R);
        end
    endtask

    task automatic test_value_change();
        int gap, bad;
        collect_scan(1'b0, 1'b1);
        n_checks++;
        if (line_of(4) !== exp_line[4]) begin
            n_fail++;
            $display("FAIL change_row4 got=\"%s\" exp=\"%s\"", line_of(4), exp_line[4]);
        end
        n_checks++;
        if (line_of(5) !== exp_line[5]) begin
            n_fail++;
            $display("FAIL change_row5 got=\"%s\" exp=\"%s\"", line_of(5), exp_line[5]);
        end
        n_checks++;
        if (done_cyc - req_cyc !== 96) begin
            n_fail++; $display("FAIL change_scan_length got=%0d exp=96", done_cyc - req_cyc);
        end
        wait_gap(gap, bad);
    endtask

    task automatic test_reset_mid();
        int k;
        bit found;
        char_ready = 1'b1;
        found = 1'b0;
        k = 0;
        while (!found && k < 200) begin
            @(negedge clk);
            k++;
            found = char_valid && char_row == 6'd1 && char_col == 4'd7;
        end
        n_checks++;
        if (!found) begin
            n_fail++; $display("FAIL midreset_reach_col7 got=0 exp=1");
        end
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (display_number !== 6'd0 || char_valid !== 1'b0 || scan_done !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_ctrl got=%0h/%b/%b exp=0/0/0", display_number, char_valid, scan_done);
        end
        n_checks++;
        if (char_data !== 8'h00 || char_row !== 6'd0 || char_col !== 4'd0) begin
            n_fail++;
            $display("FAIL midreset_char got=%0h/%0h/%0h exp=0/0/0", char_data, char_row, char_col);
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (display_number !== 6'd1 || char_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_restart got=%0h/%b exp=1/0", display_number, char_valid);
        end
        k = 0;
        while (!char_valid && k < 10) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (k !== 2) begin
            n_fail++; $display("FAIL midreset_first_char_latency got=%0d exp=2", k);
        end
        n_checks++;
        if (char_row !== 6'd1 || char_col !== 4'd0 || char_data !== 8'h41) begin
            n_fail++;
            $display("FAIL midreset_first_char got=%0h/%0h/%0h exp=1/0/41", char_row, char_col, char_data);
        end
    endtask

    initial begin
`ifdef LCD_SCAN_ZERO_SUPPRESS_EN
        exp_line[1] = "A    :      FF";
        exp_line[5] = "ZERO :       0";
        exp_line[6] = "X    :   A0B0C";
`else
        exp_line[1] = "A    :000000FF";
        exp_line[5] = "ZERO :00000000";
        exp_line[6] = "X    :000A0B0C";
`endif
        exp_line[2] = "B C  :12345678";
        exp_line[3] = "              ";
        exp_line[4] = "HELLO:DEADBEEF";

        test_reset();
        test_scan();
        test_stall();
        test_value_change();
        test_reset_mid();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_display_scanner.md
# lcd_display_scanner

- Initiator side of the LCD display-request protocol.
- Periodically walks `display_number` through entries 1..NUM_ENTRIES and captures each registered (`display_valid`, `display_name`, `display_value`) response.
- Formats each response as a 14-character ASCII text line and streams it to the LCD text renderer over a valid/ready character port.
- Sits inside the LCD subsystem, opposite any design wrapper that answers display requests.

## Interface
- NUM_ENTRIES, 6: highest entry index scanned (1..63).
- REFRESH_CYCLES, 1000000: idle cycles between end of one scan and start of the next (≥1).
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- display_number  output  6  entry index requested; 0 = no request.
- display_valid  input  1  responder has content for the requested entry.
- display_name  input  40  5 ASCII chars, [39:32] leftmost; 0x00 = blank.
- display_value  input  32  value for the entry.
- char_valid  output  1  char_data/char_row/char_col valid.
- char_data  output  8  ASCII character.
- char_row  output  6  line index = entry number.
- char_col  output  4  column 0..13.
- char_ready  input  1  renderer accepts the character.
- scan_done  output  1  one-cycle pulse at the end of each full scan.

## Operation
- States:
  - IDLE: refresh counter decrements; at 0 → REQ with idx=1.
  - REQ: display_number=idx.
  - CAP: display_number=idx; sample the three response inputs into the line buffer.
  - EMIT: stream 14 characters.
  - NEXT: if idx==NUM_ENTRIES → IDLE, pulse scan_done, reload counter to REFRESH_CYCLES-1; else idx+1 → REQ.
- display_number = 0 in IDLE, EMIT and NEXT.
- Line format:
  - Cols 0–4: name bytes, MSB first; 0x00 → 0x20.
  - Col 5: ':' (0x3A).
  - Cols 6–13: value nibbles [31:28] first, as '0'–'9' and 'A'–'F' (uppercase).
- If display_valid=0 at capture, all 14 characters are 0x20 (line blanked).
- Handshake:
  - A transfer occurs when char_valid && char_ready.
  - char_valid stays high and char_data/char_row/char_col stay stable until the transfer.
  - Column advances only on a transfer.
  - char_ready low stalls EMIT indefinitely.
- Response inputs are sampled only in CAP; changes during EMIT do not affect the line being sent.
- Reset, including mid-scan or mid-handshake: all state cleared, counter = 0, IDLE. The partially sent line is abandoned and not resumed.

## Timing
- Reset values: display_number=0, char_valid=0, char_data=0x00, char_row=0, char_col=0, scan_done=0.
- First clock edge with reset low: IDLE → REQ. display_number=1 in the following cycle.
- Responder latency is exactly one cycle. display_number=n is driven in REQ (cycle t) and held in CAP (t+1); capture happens at the end of t+1.
- char_valid rises in the cycle after CAP.
- With char_ready held high: one character per cycle, 16 cycles per entry, 16·NUM_ENTRIES cycles per scan.
- scan_done is high in the cycle after the last character of entry NUM_ENTRIES transfers.
- The next REQ occurs REFRESH_CYCLES cycles after scan_done.
- REFRESH_CYCLES=1: REQ immediately follows the IDLE cycle.

## Configuration
- LCD_SCAN_ZERO_SUPPRESS_EN defined:
  - Leading zero nibbles in cols 6–12 are emitted as 0x20.
  - Col 13 is always a digit, so value 0 shows "       0".
  - Suppression stops at the first nonzero nibble.
- Undefined: all 8 hex digits are always emitted.

## Structure
- Package `lcd_scan_pkg`:
  - LINE_CHARS=14, NAME_CHARS=5, COL_SEP=5, COL_HEX=6.
  - ASCII constants (SPACE, COLON).
  - FSM state enum.
- Sub-module `hex_ascii_encoder`: combinational 4-bit nibble → 8-bit ASCII.
- Line buffer, refresh counter, FSM and column counter live in the top.

## Test plan
- Responder model returns entry 1 = "A", value 0x0000_00FF. With char_ready=1, row 1 must be "A    :000000FF", or "A    :      FF" with LCD_SCAN_ZERO_SUPPRESS_EN.
- Entry 3 returns display_valid=0 → row 3 is 14 spaces. Rows 1–6 arrive in order. scan_done pulses once, 96 cycles after the first REQ.
- char_ready toggles 1 cycle high / 3 low during entry 2. char_data/char_col stay stable while stalled, and no character is lost or duplicated.
- Responder value changes during EMIT → transmitted line matches the value present at CAP.
- Reset asserted mid-EMIT at col 7:
  - Next cycle: all outputs are at reset values.
  - After release, the scan restarts at entry 1, col 0.
- REFRESH_CYCLES=10: the gap from scan_done to the next display_number=1 is exactly 10 cycles, and display_number=0 throughout.
